// File: rtl/ym3438_out_mix.sv
// ym3438_out_mix: per-frame stereo mixer for six time-multiplexed channels.
// Sums panned channel samples and publishes one L/R pair per frame.
module ym3438_out_mix (
  input  logic        MCLK,
  input  logic        reset,
  input  logic [8:0]  ch_out,
  input  logic [1:0]  ch_pan,
  input  logic        ch_strobe,
  input  logic        frame_start,
  output logic [11:0] out_l,
  output logic [11:0] out_r,
  output logic        out_valid,
  output logic        frame_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [2:0] LAST_SLOT = 3'd5;

  state_t      state;
  logic [2:0]  slot;
  logic [11:0] acc_l;
  logic [11:0] acc_r;

  logic [11:0] smp;
  logic [11:0] add_l;
  logic [11:0] add_r;
  logic [11:0] sum_l;
  logic [11:0] sum_r;

  logic        ev_start;
  logic        ev_step;
  logic        ev_last;
  logic        slot_ok;

  // Offset binary to signed: flip the MSB, then sign-extend.
  assign smp   = {{4{~ch_out[8]}}, ch_out[7:0]};
  assign add_l = ch_pan[1] ? smp : 12'd0;
  assign add_r = ch_pan[0] ? smp : 12'd0;
  assign sum_l = acc_l + add_l;
  assign sum_r = acc_r + add_r;

  assign slot_ok  = (slot <= LAST_SLOT);
  assign ev_start = ch_strobe & frame_start;
  assign ev_step  = ch_strobe & ~frame_start
                  & (slot != LAST_SLOT);
  assign ev_last  = ch_strobe & ~frame_start
                  & (slot == LAST_SLOT);

  // Frame FSM: collect six contributions, then publish the sums.
  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      slot      <= 3'd0;
      acc_l     <= 12'd0;
      acc_r     <= 12'd0;
      out_l     <= 12'd0;
      out_r     <= 12'd0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      if (!slot_ok) begin
        state <= IDLE;
        slot  <= 3'd0;
        acc_l <= 12'd0;
        acc_r <= 12'd0;
      end else begin
        case (state)
          IDLE: begin
            if (ev_start) begin
              state <= ACCUM;
              slot  <= 3'd1;
              acc_l <= add_l;
              acc_r <= add_r;
            end
          end
          ACCUM: begin
            unique case (1'b1)
              ev_start: begin
                frame_err <= 1'b1;
                slot      <= 3'd1;
                acc_l     <= add_l;
                acc_r     <= add_r;
              end
              ev_last: begin
                out_l     <= sum_l;
                out_r     <= sum_r;
                out_valid <= 1'b1;
                state     <= IDLE;
                slot      <= 3'd0;
                acc_l     <= 12'd0;
                acc_r     <= 12'd0;
              end
              ev_step: begin
                slot  <= slot + 3'd1;
                acc_l <= sum_l;
                acc_r <= sum_r;
              end
              default: ;
            endcase
          end
          default: begin
            state <= IDLE;
            slot  <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ym3438_out_mix.sv
// tb_ym3438_out_mix: directed frames checked against a queue-based model.
// Outputs are compared on every falling edge of MCLK.
module tb_ym3438_out_mix;

  logic        MCLK = 1'b0;
  logic        reset = 1'b0;
  logic [8:0]  ch_out = 9'h100;
  logic [1:0]  ch_pan = 2'b00;
  logic        ch_strobe = 1'b0;
  logic        frame_start = 1'b0;
  logic [11:0] out_l;
  logic [11:0] out_r;
  logic        out_valid;
  logic        frame_err;

  int vectors = 0;
  int miscompares = 0;

  ym3438_out_mix dut (
    .MCLK        (MCLK),
    .reset       (reset),
    .ch_out      (ch_out),
    .ch_pan      (ch_pan),
    .ch_strobe   (ch_strobe),
    .frame_start (frame_start),
    .out_l       (out_l),
    .out_r       (out_r),
    .out_valid   (out_valid),
    .frame_err   (frame_err)
  );

  // Clock generation
  always #5 MCLK = ~MCLK;

  // Reference model: a frame is the list of contributions since frame_start.
  int          ql[$];
  int          qr[$];
  bit          in_frame = 1'b0;
  logic [11:0] exp_l = 12'd0;
  logic [11:0] exp_r = 12'd0;
  logic        exp_v = 1'b0;
  logic        exp_e = 1'b0;

  always @(posedge MCLK or posedge reset) begin
    if (reset) begin
      ql.delete();
      qr.delete();
      in_frame = 1'b0;
      exp_l = 12'd0;
      exp_r = 12'd0;
      exp_v = 1'b0;
      exp_e = 1'b0;
    end else begin
      int v;
      int sl;
      int sr;
      exp_v = 1'b0;
      exp_e = 1'b0;
      v = int'(ch_out) - 256;
      if (ch_strobe) begin
        if (frame_start) begin
          if (in_frame) exp_e = 1'b1;
          ql.delete();
          qr.delete();
          in_frame = 1'b1;
        end
        if (in_frame) begin
          ql.push_back(ch_pan[1] ? v : 0);
          qr.push_back(ch_pan[0] ? v : 0);
          if (ql.size() == 6) begin
            sl = 0;
            sr = 0;
            foreach (ql[i]) sl += ql[i];
            foreach (qr[i]) sr += qr[i];
            exp_l = sl[11:0];
            exp_r = sr[11:0];
            exp_v = 1'b1;
            in_frame = 1'b0;
          end
        end
      end
    end
  end

  task automatic check(input string name,
                       input logic [11:0] got,
                       input logic [11:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h t=%0t",
               name, got, want, $time);
    end
  endtask

  // Per-cycle comparison against the model
  initial begin
    @(negedge MCLK);
    forever begin
      check("out_l", out_l, exp_l);
      check("out_r", out_r, exp_r);
      check("out_valid", {11'd0, out_valid}, {11'd0, exp_v});
      check("frame_err", {11'd0, frame_err}, {11'd0, exp_e});
      @(negedge MCLK);
    end
  end

  task automatic send(input logic [8:0] d,
                      input logic [1:0] p,
                      input logic fs);
    ch_out = d;
    ch_pan = p;
    ch_strobe = 1'b1;
    frame_start = fs;
    @(posedge MCLK);
    #1;
    ch_strobe = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge MCLK);
      #1;
    end
  endtask

  task automatic frame(input logic [8:0] d,
                       input logic [1:0] p);
    send(d, p, 1'b1);
    for (int i = 0; i < 5; i++) send(d, p, 1'b0);
  endtask

  initial begin
    #1 reset = 1'b1;
    @(negedge MCLK);
    check("rst_l", out_l, 12'h000);
    check("rst_r", out_r, 12'h000);
    check("rst_v", {11'd0, out_valid}, 12'd0);
    check("rst_e", {11'd0, frame_err}, 12'd0);
    @(posedge MCLK);
    #1 reset = 1'b0;

    // Full-scale positive, both sides
    frame(9'h1FF, 2'b11);
    check("pos_v", {11'd0, out_valid}, 12'd1);
    check("pos_l", out_l, 12'h5FA);
    check("pos_r", out_r, 12'h5FA);
    check("pos_model", exp_l, 12'h5FA);
    idle(1);
    check("pos_v_drop", {11'd0, out_valid}, 12'd0);
    check("pos_hold", out_l, 12'h5FA);
    idle(2);

    // Full-scale negative, left only
    frame(9'h000, 2'b10);
    check("neg_l", out_l, 12'hA00);
    check("neg_r", out_r, 12'h000);
    check("neg_model", exp_l, 12'hA00);
    idle(2);

    // Early restart discards the partial sums
    send(9'h1FF, 2'b11, 1'b1);
    send(9'h1FF, 2'b11, 1'b0);
    send(9'h1FF, 2'b11, 1'b0);
    send(9'h101, 2'b11, 1'b1);
    check("restart_err", {11'd0, frame_err}, 12'd1);
    check("restart_v", {11'd0, out_valid}, 12'd0);
    for (int i = 0; i < 5; i++) send(9'h100, 2'b11, 1'b0);
    check("restart_l", out_l, 12'h001);
    check("restart_r", out_r, 12'h001);
    check("restart_model", exp_r, 12'h001);
    idle(1);

    // Mixed pans within one frame: L=+10-3+100, R=+10+7-56
    send(9'h10A, 2'b11, 1'b1);
    send(9'h0FD, 2'b10, 1'b0);
    send(9'h107, 2'b01, 1'b0);
    send(9'h164, 2'b10, 1'b0);
    send(9'h0C8, 2'b01, 1'b0);
    send(9'h1FF, 2'b00, 1'b0);
    check("mix_l", out_l, 12'h06B);
    check("mix_r", out_r, 12'hFD9);
    idle(2);

    // Reset mid-frame, then strobes without frame_start
    reset = 1'b1;
    #3 reset = 1'b0;
    send(9'h1FF, 2'b11, 1'b1);
    for (int i = 0; i < 3; i++) send(9'h1FF, 2'b11, 1'b0);
    reset = 1'b1;
    #3 reset = 1'b0;
    send(9'h1FF, 2'b11, 1'b0);
    send(9'h1FF, 2'b11, 1'b0);
    check("rstmid_l", out_l, 12'h000);
    check("rstmid_v", {11'd0, out_valid}, 12'd0);
    idle(2);

    // Seventh strobe is ignored
    frame(9'h180, 2'b11);
    check("seven_l", out_l, 12'h300);
    send(9'h1FF, 2'b11, 1'b0);
    check("seven_v", {11'd0, out_valid}, 12'd0);
    frame(9'h101, 2'b11);
    check("next_l", out_l, 12'h006);
    check("next_r", out_r, 12'h006);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
